// File: rtl/sd_sector_arbiter.sv
// rtl/sd_sector_arbiter.sv - round-robin owner of the single SD sector channel shared by NDRV drives
// One sector transfer at a time; LBA and op are frozen from grant until the FSM is back in IDLE.
module sd_sector_arbiter #(
   parameter int NDRV    = 2,
   parameter int TIMEOUT = 2**24
) (
   input  logic                 i_clk_sys,
   input  logic                 i_reset,
   input  logic [32*NDRV-1:0]   i_req_lba,
   input  logic [NDRV-1:0]      i_req_rd,
   input  logic [NDRV-1:0]      i_req_wr,
   input  logic [8*NDRV-1:0]    i_req_din,
   output logic [NDRV-1:0]      o_req_ack,
   output logic [NDRV-1:0]      o_req_done,
   output logic [NDRV-1:0]      o_req_err,
   output logic [NDRV-1:0]      o_req_dout_strobe,
   output logic [31:0]          o_sd_lba,
   output logic                 o_sd_rd,
   output logic                 o_sd_wr,
   input  logic                 i_sd_ack,
   input  logic                 i_sd_dout_strobe,
   output logic [7:0]           o_sd_din,
   output logic [1:0]           o_active
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_WAIT_REL} state_t;

   state_t          r_state;
   logic [1:0]      r_rr;
   logic [1:0]      r_active;
   logic [CW-1:0]   r_count;
   logic [31:0]     r_sd_lba;
   logic            r_sd_rd;
   logic            r_sd_wr;
   logic [NDRV-1:0] r_req_ack;
   logic [NDRV-1:0] r_req_done;
   logic [NDRV-1:0] r_req_err;

   logic [NDRV-1:0] w_pending;
   logic            w_found;
   logic [1:0]      w_grant;
   logic [31:0]     w_grant_lba;
   logic            w_grant_rd;
   logic            w_own_pend;
   logic [NDRV-1:0] w_own_onehot;
   logic [1:0]      w_rr_next;

   assign w_pending = i_req_rd | i_req_wr;
   assign w_rr_next = (r_active == 2'(NDRV-1)) ? 2'd0 : r_active + 2'd1;

   // First pending requester at or after the round-robin pointer, wrapping to 0.
   always_comb begin
      w_found = 1'b0;
      w_grant = 2'd0;
      for (int k = 0; k < NDRV; k++) begin
         for (int j = 0; j < NDRV; j++) begin
            if (!w_found && w_pending[j] && (((int'(r_rr) + k) % NDRV) == j)) begin
               w_found = 1'b1;
               w_grant = 2'(j);
            end
         end
      end
   end

   always_comb begin
      w_grant_lba  = 32'd0;
      w_grant_rd   = 1'b0;
      w_own_pend   = 1'b0;
      w_own_onehot = '0;
      for (int j = 0; j < NDRV; j++) begin
         if (w_grant == 2'(j)) begin
            w_grant_lba = i_req_lba[32*j +: 32];
            w_grant_rd  = i_req_rd[j];
         end
         if (r_active == 2'(j)) begin
            w_own_pend      = w_pending[j];
            w_own_onehot[j] = 1'b1;
         end
      end
   end

   // Data path only follows the owner while the host is actually moving bytes.
   always_comb begin
      o_sd_din          = 8'd0;
      o_req_dout_strobe = '0;
      if (r_state == S_XFER) begin
         for (int j = 0; j < NDRV; j++) begin
            if (r_active == 2'(j)) begin
               o_sd_din             = i_req_din[8*j +: 8];
               o_req_dout_strobe[j] = i_sd_dout_strobe;
            end
         end
      end
   end

   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_rr       <= 2'd0;
         r_active   <= 2'd0;
         r_count    <= '0;
         r_sd_lba   <= 32'd0;
         r_sd_rd    <= 1'b0;
         r_sd_wr    <= 1'b0;
         r_req_ack  <= '0;
         r_req_done <= '0;
         r_req_err  <= '0;
      end else begin
         r_req_done <= '0;
         r_req_err  <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_active <= w_grant;
                  r_sd_lba <= w_grant_lba;
                  r_sd_rd  <= w_grant_rd;
                  r_sd_wr  <= !w_grant_rd;
                  r_count  <= '0;
                  r_state  <= S_REQ;
               end
            end
            S_REQ: begin
               r_count <= r_count + 1'b1;
               if (i_sd_ack) begin
                  r_sd_rd   <= 1'b0;
                  r_sd_wr   <= 1'b0;
                  r_req_ack <= w_own_onehot;
                  r_state   <= S_XFER;
               end else if (!w_own_pend) begin
                  r_sd_rd <= 1'b0;
                  r_sd_wr <= 1'b0;
                  r_state <= S_WAIT_REL;
               end else if (r_count == CW'(TIMEOUT-1)) begin
                  r_sd_rd   <= 1'b0;
                  r_sd_wr   <= 1'b0;
                  r_req_err <= w_own_onehot;
                  r_rr      <= w_rr_next;
                  r_state   <= S_WAIT_REL;
               end
            end
            S_XFER: begin
               if (!i_sd_ack) begin
                  r_req_ack  <= '0;
                  r_req_done <= w_own_onehot;
                  r_rr       <= w_rr_next;
                  r_state    <= S_WAIT_REL;
               end
            end
            S_WAIT_REL: r_state <= S_IDLE;
            default:    r_state <= S_IDLE;
         endcase
      end
   end

   assign o_req_ack  = r_req_ack;
   assign o_req_done = r_req_done;
   assign o_req_err  = r_req_err;
   assign o_sd_lba   = r_sd_lba;
   assign o_sd_rd    = r_sd_rd;
   assign o_sd_wr    = r_sd_wr;
   assign o_active   = r_active;

endmodule

// File: tb/tb_sd_sector_arbiter.sv
// tb/tb_sd_sector_arbiter.sv - self-checking bench for sd_sector_arbiter
// The bench plays both the drive controllers and user_io; grant order comes from a pointer/pending model.
module tb_sd_sector_arbiter;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [31:0] lba [2];
   logic [7:0]  din [2];
   logic [1:0]  rd, wr;
   logic        sd_ack, sd_dout_strobe;
   logic [63:0] w_req_lba;
   logic [15:0] w_req_din;
   logic [1:0]  o_req_ack, o_req_done, o_req_err, o_req_dout_strobe, o_active;
   logic [31:0] o_sd_lba;
   logic        o_sd_rd, o_sd_wr;
   logic [7:0]  o_sd_din;

   int n_vec = 0;
   int n_miss = 0;
   int m_rr = 0;

   always #5 clk = ~clk;

   assign w_req_lba = {lba[1], lba[0]};
   assign w_req_din = {din[1], din[0]};

   sd_sector_arbiter #(.NDRV(2), .TIMEOUT(16)) dut (
      .i_clk_sys(clk), .i_reset(i_reset),
      .i_req_lba(w_req_lba), .i_req_rd(rd), .i_req_wr(wr), .i_req_din(w_req_din),
      .o_req_ack(o_req_ack), .o_req_done(o_req_done), .o_req_err(o_req_err),
      .o_req_dout_strobe(o_req_dout_strobe),
      .o_sd_lba(o_sd_lba), .o_sd_rd(o_sd_rd), .o_sd_wr(o_sd_wr),
      .i_sd_ack(sd_ack), .i_sd_dout_strobe(sd_dout_strobe),
      .o_sd_din(o_sd_din), .o_active(o_active)
   );

   typedef struct {
      logic [1:0] rd;
      logic [1:0] wr;
      int         n;
      logic [7:0] g;   // k-th expected grant in bits [2k+:2]
      logic [3:0] r;   // k-th expected op is a read
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rd = 2'b00; wr = 2'b00; sd_ack = 1'b0; sd_dout_strobe = 1'b0;
      i_reset = 1'b1;
      repeat (2) @(negedge clk);
      i_reset = 1'b0;
      m_rr = 0;
   endtask

   // Acts as user_io for one sector transfer and as the owning drive releasing its request.
   task automatic serve(input int g, input bit exp_rd, input int nstb, input bit allow_new);
      logic [1:0]  oh;
      logic [31:0] exp_lba;
      int t;
      oh = 2'b01 << g;
      t = 0;
      while (!(o_sd_rd || o_sd_wr) && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("grant_seen", 32'(t < 50), 32'd1);
      check("active", 32'(o_active), 32'(g));
      exp_lba = lba[g];
      check("sd_lba", o_sd_lba, exp_lba);
      check("sd_rd", 32'(o_sd_rd), 32'(exp_rd));
      check("sd_wr", 32'(o_sd_wr), 32'(!exp_rd));
      check("ack_early", 32'(o_req_ack), 32'd0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sd_ack = 1'b1;
      @(negedge clk);
      check("op_drop", 32'({o_sd_rd, o_sd_wr}), 32'd0);
      check("req_ack", 32'(o_req_ack), 32'(oh));
      check("sd_din", 32'(o_sd_din), 32'(din[g]));
      lba[g] = $urandom;
      if (allow_new) begin
         for (int i = 0; i < 2; i++) begin
            if (i != g && !rd[i] && !wr[i] && $urandom_range(0, 2) == 0) begin
               if ($urandom_range(0, 1) == 1) rd[i] = 1'b1;
               else wr[i] = 1'b1;
            end
         end
      end
      for (int s = 0; s < nstb; s++) begin
         sd_dout_strobe = 1'b1;
         #1 check("strobe_on", 32'(o_req_dout_strobe), 32'(oh));
         @(negedge clk);
         sd_dout_strobe = 1'b0;
         #1 check("strobe_off", 32'(o_req_dout_strobe), 32'd0);
      end
      check("lba_frozen", o_sd_lba, exp_lba);
      sd_ack = 1'b0;
      @(negedge clk);
      check("done", 32'(o_req_done), 32'(oh));
      check("ack_drop", 32'(o_req_ack), 32'd0);
      check("err_none", 32'(o_req_err), 32'd0);
      check("din_idle", 32'(o_sd_din), 32'd0);
      if (exp_rd) rd[g] = 1'b0;
      else wr[g] = 1'b0;
      m_rr = (g + 1) % 2;
      @(negedge clk);
      check("done_pulse", 32'(o_req_done), 32'd0);
   endtask

   initial begin
      int cnt, g;
      bit exp_rd;
      tbl[0] = '{rd: 2'b11, wr: 2'b00, n: 2, g: 8'h04, r: 4'b0011};
      tbl[1] = '{rd: 2'b00, wr: 2'b10, n: 1, g: 8'h01, r: 4'b0000};
      tbl[2] = '{rd: 2'b01, wr: 2'b01, n: 2, g: 8'h00, r: 4'b0001};
      tbl[3] = '{rd: 2'b10, wr: 2'b01, n: 2, g: 8'h01, r: 4'b0001};
      tbl[4] = '{rd: 2'b01, wr: 2'b10, n: 2, g: 8'h01, r: 4'b0010};
      tbl[5] = '{rd: 2'b11, wr: 2'b11, n: 4, g: 8'h11, r: 4'b0011};
      lba[0] = 32'd0; lba[1] = 32'd0; din[0] = 8'd0; din[1] = 8'd0;
      do_reset();

      check("rst_sd_rd", 32'({o_sd_rd, o_sd_wr}), 32'd0);
      check("rst_lba", o_sd_lba, 32'd0);
      check("rst_active", 32'(o_active), 32'd0);
      check("rst_flags", 32'({o_req_ack, o_req_done, o_req_err}), 32'd0);
      check("rst_din", 32'(o_sd_din), 32'd0);

      // Single read of 512 bytes from drive 0.
      lba[0] = 32'h123; din[0] = 8'h3C; rd = 2'b01;
      @(negedge clk);
      check("grant_latency", 32'(o_sd_rd), 32'd1);
      check("lba_0x123", o_sd_lba, 32'h123);
      serve(0, 1'b1, 512, 1'b0);

      do_reset();
      foreach (tbl[v]) begin
         lba[0] = $urandom; lba[1] = $urandom;
         din[0] = 8'($urandom); din[1] = 8'($urandom);
         if (v == 1) din[1] = 8'hA5;
         rd = tbl[v].rd; wr = tbl[v].wr;
         for (int k = 0; k < tbl[v].n; k++)
            serve(int'(tbl[v].g[2*k +: 2]), tbl[v].r[k], int'($urandom_range(1, 4)), 1'b0);
      end

      // Owner withdrawing before ack: no done, no err.
      do_reset();
      rd = 2'b01;
      @(negedge clk);
      check("wd_req", 32'(o_sd_rd), 32'd1);
      rd = 2'b00;
      @(negedge clk);
      check("wd_drop", 32'(o_sd_rd), 32'd0);
      check("wd_flags", 32'({o_req_done, o_req_err}), 32'd0);
      @(negedge clk);
      check("wd_flags2", 32'({o_req_done, o_req_err, o_sd_rd}), 32'd0);

      // Timeout with no sd_ack.
      do_reset();
      rd = 2'b01;
      @(negedge clk);
      cnt = 0;
      while (o_sd_rd && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      check("timeout_cycles", 32'(cnt), 32'd16);
      check("timeout_err", 32'(o_req_err), 32'd1);
      check("timeout_nodone", 32'(o_req_done), 32'd0);
      rd = 2'b00;
      @(negedge clk);
      check("err_pulse", 32'(o_req_err), 32'd0);

      // Reset in XFER, then a stray ack while idle.
      do_reset();
      rd = 2'b10;
      @(negedge clk);
      check("rx_req", 32'(o_sd_rd), 32'd1);
      sd_ack = 1'b1;
      @(negedge clk);
      check("rx_ack", 32'(o_req_ack), 32'd2);
      i_reset = 1'b1; rd = 2'b00;
      @(negedge clk);
      i_reset = 1'b0;
      check("rx_clear", 32'({o_req_ack, o_req_done, o_req_err, o_sd_rd, o_sd_wr}), 32'd0);
      check("rx_lba", o_sd_lba, 32'd0);
      for (int i = 0; i < 3; i++) begin
         sd_dout_strobe = 1'b1;
         #1 check("stray_strobe", 32'({o_req_dout_strobe, o_sd_din}), 32'd0);
         @(negedge clk);
         check("stray_ack", 32'({o_req_ack, o_sd_rd, o_sd_wr}), 32'd0);
      end
      sd_dout_strobe = 1'b0; sd_ack = 1'b0;

      // Random traffic against the pending/pointer model.
      do_reset();
      for (int round = 0; round < 40; round++) begin
         if ((rd | wr) == 2'b00) begin
            rd = 2'($urandom); wr = 2'($urandom);
            if ((rd | wr) == 2'b00) rd[$urandom_range(0, 1)] = 1'b1;
            lba[0] = $urandom; lba[1] = $urandom;
            din[0] = 8'($urandom); din[1] = 8'($urandom);
         end
         g = -1;
         for (int k = 0; k < 2; k++)
            if (g < 0 && (rd[(m_rr + k) % 2] || wr[(m_rr + k) % 2])) g = (m_rr + k) % 2;
         exp_rd = rd[g];
         serve(g, exp_rd, int'($urandom_range(1, 4)), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
